// File: rtl/mem_arbiter_pkg.sv
// Shared stack machine package slice for the external memory arbiter.
// Contents:
//   mem_arb_state_e  arbiter FSM states (IDLE, ACCESS, RDATA)
//   ARB_CORE/ARB_DBG requester indices (core = port 0, debug/loader = port 1)
//   port_onehot()    converts a requester index into a per-port pulse vector
package StackMachine_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } mem_arb_state_e;

  localparam logic ARB_CORE = 1'b0;
  localparam logic ARB_DBG  = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational winner selection for the two-port memory arbiter.
// Ports:
//   req[1:0]  in   pending requests (bit 0 core, bit 1 debug/loader)
//   last      in   requester served by the most recent access
//   winner    out  index of the requester to serve next (only meaningful if |req)
// Build option: MEM_ARB_DEBUG_PRIORITY_EN gives port 1 absolute priority and
// ignores last; otherwise contention alternates between the two ports.
module rr_pick2
  import StackMachine_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

`ifdef MEM_ARB_DEBUG_PRIORITY_EN
  // A loader holding req[1] starves the core on purpose.
  logic unused_last;
  assign unused_last = last;
  assign winner      = req[1] ? ARB_DBG : ARB_CORE;
`else
  always_comb begin
    winner = ARB_CORE;
    if (&req) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = ARB_DBG;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises reads and writes from the stack machine core (port 0)
// and the debug/program loader (port 1) onto one 8-bit memory port. One access
// in flight at a time; read data returns to the requester that issued it.
// Ports:
//   clock, reset_n           clock and synchronous active-low reset
//   req, we                  per-port request / write enable
//   addr0/1, wdata0/1        per-port address and write data
//   gnt                      one-cycle pulse when the access is issued
//   rvalid, rdata            one-cycle read-return pulse and shared read data
//   busy                     FSM not idle
//   mem_en, mem_we,
//   mem_addr, mem_wdata      memory strobe, write enable, address, write data
//   mem_rdata                memory read data, valid the cycle after a read strobe
// Build option: MEM_ARB_DEBUG_PRIORITY_EN (port 1 absolute priority, see rr_pick2).
//
// state  | meaning
// IDLE   | sample req, latch the winner's transaction
// ACCESS | drive memory strobe, pulse gnt[owner]
// RDATA  | capture mem_rdata; rvalid[owner] pulses in the following IDLE cycle
module mem_arbiter
  import StackMachine_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  mem_arb_state_e state;
  logic           owner;
  logic           last;
  logic           winner;
  logic           lat_we;
  logic [AW-1:0]  lat_addr;
  logic [DW-1:0]  lat_wdata;
  logic [1:0]     rvalid_q;
  logic [DW-1:0]  rdata_q;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .winner (winner)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= ARB_CORE;
      last      <= ARB_DBG;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rvalid_q  <= 2'b00;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= winner;
            lat_we    <= we[winner];
            lat_addr  <= (winner == ARB_DBG) ? addr1 : addr0;
            lat_wdata <= (winner == ARB_DBG) ? wdata1 : wdata0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          last  <= owner;
          state <= lat_we ? IDLE : RDATA;
        end
        RDATA: begin
          rdata_q  <= mem_rdata;
          rvalid_q <= port_onehot(owner);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are held at zero outside ACCESS so the bus is quiet
  // between transactions.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & lat_we;
  assign mem_addr  = mem_en ? lat_addr : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;

  assign gnt    = mem_en ? port_onehot(owner) : 2'b00;
  assign busy   = (state != IDLE);
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
